bios_loader: RTL and testbench

Write-side companion to the BIOS memory. Accepts a framed byte stream (typically from the UART receiver), assembles little-endian 32-bit words and writes them sequentially into the BIOS instruction memory starting at word address 0. It validates the frame length and an 8-bit additive checksum, and reports completion or failure to the boot controller.

---
 rtl/bios_loader_if.sv | 28 ++
 rtl/bios_loader.sv | 165 ++++++++++++++++
 tb/tb_bios_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bios_loader_if.sv
// Byte-stream, memory-write and status signals of the BIOS loader.
// The master side feeds bytes and start; the slave (loader) writes memory and reports status.
interface bios_loader_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned XLEN       = 32
);
  logic                  start;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [XLEN-1:0]       mem_wdata;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   words_written;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written
  );
endinterface

// File: rtl/bios_loader.sv
// BIOS loader: receives a framed byte stream (4-byte LE length, N LE words, additive checksum),
// writes the words to BIOS memory from address 0 and reports done or error.
module bios_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned XLEN       = 32
) (
  input logic          clk,
  input logic          reset,
  bios_loader_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StDone, StErr} state_e;

  localparam logic [31:0] MaxWords = 32'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;          // byte lane within the current 4-byte group
  logic [XLEN-9:0]       buf_q, buf_d;          // lower three bytes of the group being assembled
  logic [ADDR_WIDTH:0]   nwords_q, nwords_d;    // validated frame length in words
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;        // words fully received so far
  logic [7:0]            csum_q, csum_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;

  logic                  accept;
  logic [XLEN-1:0]       group_full;
  logic [ADDR_WIDTH:0]   wcnt_inc;

  assign accept     = bus.byte_valid && byte_ready_q;
  assign group_full = {bus.byte_in, buf_q};
  assign wcnt_inc   = wcnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Next-state logic for the frame parser and all registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    nwords_d     = nwords_q;
    wcnt_d       = wcnt_q;
    csum_d       = csum_q;
    byte_ready_d = byte_ready_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    // The counter trails the write strobe by one cycle.
    words_d      = words_q + {{ADDR_WIDTH{1'b0}}, mem_we_q};

    case (state_q)
      StIdle, StDone, StErr: begin
        if (bus.start) begin
          state_d      = StLen;
          cnt_d        = 2'd0;
          wcnt_d       = '0;
          csum_d       = 8'd0;
          words_d      = '0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          byte_ready_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      StLen: begin
        if (accept) begin
          buf_d = {bus.byte_in, buf_q[XLEN-9:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (group_full == 32'd0 || group_full > MaxWords) begin
              state_d      = StErr;
              error_d      = 1'b1;
              byte_ready_d = 1'b0;
              busy_d       = 1'b0;
            end else begin
              state_d  = StData;
              nwords_d = group_full[ADDR_WIDTH:0];
            end
          end
        end
      end
      StData: begin
        if (accept) begin
          buf_d  = {bus.byte_in, buf_q[XLEN-9:8]};
          cnt_d  = cnt_q + 2'd1;
          csum_d = csum_q + bus.byte_in;
          if (cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wcnt_q[ADDR_WIDTH-1:0];
            mem_wdata_d = group_full;
            wcnt_d      = wcnt_inc;
            if (wcnt_inc == nwords_q) begin
              state_d = StCsum;
            end
          end
        end
      end
      StCsum: begin
        if (accept) begin
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
          if (bus.byte_in == csum_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; synchronous reset discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      buf_q        <= '0;
      nwords_q     <= '0;
      wcnt_q       <= '0;
      csum_q       <= 8'd0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      nwords_q     <= nwords_d;
      wcnt_q       <= wcnt_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      words_q      <= words_d;
    end
  end

  assign bus.byte_ready    = byte_ready_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.words_written = words_q;

endmodule

// File: tb/tb_bios_loader.sv
// Scoreboard bench for bios_loader: a frame-level model queues the required memory writes and
// completion status; a negedge monitor pops and compares whenever the DUT writes or finishes.
module tb_bios_loader;
  localparam int unsigned AW = 12;
  localparam int unsigned XW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bios_loader_if #(.ADDR_WIDTH(AW), .XLEN(XW)) bus ();
  bios_loader #(.ADDR_WIDTH(AW), .XLEN(XW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [43:0] exp_wr[$];   // {addr, data}
  logic [14:0] exp_out[$];  // {done, error, words_written}
  logic [31:0] words[$];    // payload of the next frame

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe and every completion edge is matched against the scoreboard.
  logic        done_prev = 1'b0;
  logic        err_prev = 1'b0;
  logic [43:0] mon_wr;
  logic [14:0] mon_out;
  always @(negedge clk) begin
    if (reset) begin
      done_prev <= 1'b0;
      err_prev  <= 1'b0;
    end else begin
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write required",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          mon_wr = exp_wr.pop_front();
          check("wr_addr", 64'(bus.mem_addr), 64'(mon_wr[43:32]));
          check("wr_data", 64'(bus.mem_wdata), 64'(mon_wr[31:0]));
        end
      end
      if ((bus.done && !done_prev) || (bus.error && !err_prev)) begin
        if (exp_out.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_completion: done %0b error %0b", bus.done, bus.error);
        end else begin
          mon_out = exp_out.pop_front();
          check("done", 64'(bus.done), 64'(mon_out[14]));
          check("error", 64'(bus.error), 64'(mon_out[13]));
          check("words_written", 64'(bus.words_written), 64'(mon_out[12:0]));
          check("ready_low_at_end", 64'(bus.byte_ready), 64'd0);
          check("busy_low_at_end", 64'(bus.busy), 64'd0);
        end
      end
      done_prev <= bus.done;
      err_prev  <= bus.error;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_error"}, 64'(bus.error), 64'd0);
    check({tag, "_words_written"}, 64'(bus.words_written), 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 with the loader in its length phase.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("ready_after_start", 64'(bus.byte_ready), 64'd1);
    check("done_cleared", 64'(bus.done), 64'd0);
    check("error_cleared", 64'(bus.error), 64'd0);
    check("words_cleared", 64'(bus.words_written), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Model the frame, queue its expected effects, then stream it.
  // stop_after >= 0 truncates the stream (no expectations queued); start_at marks a byte that
  // is sent together with a start pulse.
  task automatic run_load(input logic [31:0] n, input logic [7:0] csum_byte, input int gap_max,
                          input int start_at, input int stop_after);
    logic [7:0]  bytes[$];
    logic [7:0]  sum;
    logic [31:0] w;
    bit          len_ok;
    bit          acc;
    int          lat;
    int          limit;
    sum    = 8'd0;
    len_ok = (n != 32'd0) && (n <= 32'd4096);
    for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
    if (len_ok) begin
      for (int i = 0; i < int'(n); i++) begin
        w = words[i];
        for (int b = 0; b < 4; b++) begin
          bytes.push_back(w[8*b +: 8]);
          sum = sum + w[8*b +: 8];
        end
        if (stop_after < 0) exp_wr.push_back({12'(i), w});
      end
      bytes.push_back(csum_byte);
      if (stop_after < 0) exp_out.push_back({csum_byte == sum, csum_byte != sum, 13'(n)});
    end else if (stop_after < 0) begin
      exp_out.push_back({1'b0, 1'b1, 13'd0});
    end

    pulse_start();
    limit = (stop_after >= 0) ? stop_after : bytes.size();
    for (int idx = 0; idx < limit; idx++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        @(posedge clk);
        #1;
      end
      bus.byte_valid = 1'b1;
      bus.byte_in    = bytes[idx];
      if (idx == start_at) bus.start = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
        @(negedge clk);
        acc = bus.byte_ready;
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
      if (!acc) begin
        vectors++;
        miscompares++;
        $display("FAIL byte_accept_timeout: byte %0d never accepted, ready stayed 0", idx);
        bus.byte_valid = 1'b0;
        return;
      end
    end
    bus.byte_valid = 1'b0;
    if (stop_after >= 0) return;

    lat = -1;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.done || bus.error) lat = c;
    end
    if (lat < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL completion_timeout: no done/error, required within 1 cycle");
    end else begin
      check("completion_latency", 64'(lat), 64'd0);
    end
    @(posedge clk);
    #1;
    check("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    check("outcome_outstanding", 64'(exp_out.size()), 64'd0);
    exp_wr.delete();
    exp_out.delete();
  endtask

  task automatic set_basic();
    words.delete();
    words.push_back(32'h0000_0013);
    words.push_back(32'hDEAD_BEEF);
  endtask

  function automatic logic [7:0] word_sum(input int n);
    logic [7:0]  s;
    logic [31:0] w;
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = words[i];
      s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
    end
    return s;
  endfunction

  initial begin
    int n;
    bus.start      = 1'b0;
    bus.byte_in    = 8'd0;
    bus.byte_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic load and bad checksum.
    set_basic();
    run_load(32'd2, 8'h4B, 0, -1, -1);
    run_load(32'd2, 8'h4C, 0, -1, -1);

    // Length bounds.
    run_load(32'd0, 8'h00, 0, -1, -1);
    run_load(32'd4097, 8'h00, 0, -1, -1);

    // Flow control with random gaps.
    repeat (3) run_load(32'd2, 8'h4B, 5, -1, -1);

    // Reset after six bytes, then a full reload from address 0.
    run_load(32'd2, 8'h4B, 0, -1, 6);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    run_load(32'd2, 8'h4B, 0, -1, -1);

    // Start pulsed during the data phase is ignored; the next load restarts from DONE.
    run_load(32'd2, 8'h4B, 0, 6, -1);
    run_load(32'd2, 8'h4B, 0, -1, -1);

    // Random frames against the model.
    repeat (10) begin
      n = $urandom_range(16, 1);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load(32'(n), ($urandom_range(3, 0) == 0) ? word_sum(n) + 8'd1 : word_sum(n),
               3, -1, -1);
    end

    // Maximum legal length fills the whole memory.
    words.delete();
    for (int i = 0; i < 4096; i++) words.push_back($urandom);
    run_load(32'd4096, word_sum(4096), 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not complete in time");
    $fatal(1, "timeout");
  end
endmodule
